// File: rtl/fsm_trace_checker.sv
// Compares the behavioural, ROM and gate-level FSM output buses sample by sample,
// counts samples and disagreements, latches the first divergence and traces s_ref.
module fsm_trace_checker #(
  parameter int W     = 3,
  parameter int CNT_W = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     s_ref,
  input  logic [W-1:0]     s_mem,
  input  logic [W-1:0]     s_gate,
  output logic             mismatch,
  output logic             err_sticky,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [3*W-1:0]   first_err_vals,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             rd_valid,
  output logic             trace_empty,
  output logic             trace_full,
  output logic             trace_ovf,
  output logic [1:0]       state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Handshake: a trace entry is popped on any edge where rd_en=1 and the FIFO
  // is non-empty (and no clr); the entry appears on rd_data with rd_valid=1 for
  // exactly the following cycle. There is no backpressure on the sample side.

  state_t state_q, state_d;
  logic   sample;
  logic   diff;
  logic   do_push, do_pop;
  logic [CNT_W-1:0] cyc_next;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: begin
          if (sample) state_d = (cyc_next == CNT_MAX) ? S_HALT : S_RUN;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    halted    = (state_q == S_HALT);
    sample    = en && !clr && (state_q != S_HALT);
    state_dbg = state_q;
  end

  assign cyc_next    = cyc_count + 1'b1;
  assign diff        = (s_ref != s_mem) || (s_mem != s_gate) || (s_ref != s_gate);
  assign trace_empty = (occ == '0);
  assign trace_full  = (occ == OCC_FULL);
  assign do_pop      = rd_en && !clr && !trace_empty;
  // A push into a full FIFO only succeeds when a pop frees a slot on the same edge.
  assign do_push     = sample && (!trace_full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch       <= 1'b0;
      err_sticky     <= 1'b0;
      cyc_count      <= '0;
      err_count      <= '0;
      first_err_cyc  <= '0;
      first_err_vals <= '0;
    end else if (clr) begin
      mismatch       <= 1'b0;
      err_sticky     <= 1'b0;
      cyc_count      <= '0;
      err_count      <= '0;
      first_err_cyc  <= '0;
      first_err_vals <= '0;
    end else if (sample) begin
      mismatch  <= diff;
      cyc_count <= cyc_next;
      if (diff) begin
        if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
        if (!err_sticky) begin
          err_sticky     <= 1'b1;
          first_err_cyc  <= cyc_count;
          first_err_vals <= {s_ref, s_mem, s_gate};
        end
      end
    end
  end

  // Trace storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= s_ref;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      trace_ovf <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      trace_ovf <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (sample && !do_push) trace_ovf <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Bench for fsm_trace_checker: two instances (CNT_W=8 and CNT_W=4) driven in
// lockstep and compared every cycle against a queue-based behavioural model.
module tb_fsm_trace_checker;

  localparam int W = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic clr = 1'b0, en = 1'b0, rd_en = 1'b0;
  logic [W-1:0] s_ref = '0, s_mem = '0, s_gate = '0;

  logic       mm0, es0, h0, rv0, te0, tf0, to0;
  logic [7:0] cc0, ec0, fc0;
  logic [8:0] fv0;
  logic [2:0] rd0;
  logic [1:0] st0;

  logic       mm1, es1, h1, rv1, te1, tf1, to1;
  logic [3:0] cc1, ec1, fc1;
  logic [8:0] fv1;
  logic [2:0] rd1;
  logic [1:0] st1;

  fsm_trace_checker #(.W(W), .CNT_W(8), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .clr(clr), .en(en),
    .s_ref(s_ref), .s_mem(s_mem), .s_gate(s_gate),
    .mismatch(mm0), .err_sticky(es0), .halted(h0),
    .cyc_count(cc0), .err_count(ec0), .first_err_cyc(fc0), .first_err_vals(fv0),
    .rd_en(rd_en), .rd_data(rd0), .rd_valid(rv0),
    .trace_empty(te0), .trace_full(tf0), .trace_ovf(to0), .state_dbg(st0)
  );

  fsm_trace_checker #(.W(W), .CNT_W(4), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .en(en),
    .s_ref(s_ref), .s_mem(s_mem), .s_gate(s_gate),
    .mismatch(mm1), .err_sticky(es1), .halted(h1),
    .cyc_count(cc1), .err_count(ec1), .first_err_cyc(fc1), .first_err_vals(fv1),
    .rd_en(rd_en), .rd_data(rd1), .rd_valid(rv1),
    .trace_empty(te1), .trace_full(tf1), .trace_ovf(to1), .state_dbg(st1)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q [2][$];
  int m_cyc [2], m_err [2], m_fec [2], m_fev [2], m_rdd [2];
  bit m_mm [2], m_st [2], m_halt [2], m_rdv [2], m_ovf [2];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      m_cyc[i] = 0; m_err[i] = 0; m_fec[i] = 0; m_fev[i] = 0; m_rdd[i] = 0;
      m_mm[i] = 0; m_st[i] = 0; m_halt[i] = 0; m_rdv[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit e, input bit c, input bit r,
                            input logic [2:0] a, input logic [2:0] b, input logic [2:0] g);
    int mx;
    bit samp, pop, dis;
    mx = (i == 0) ? 255 : 15;
    if (c) begin
      exp_q[i].delete();
      m_cyc[i] = 0; m_err[i] = 0; m_fec[i] = 0; m_fev[i] = 0; m_rdd[i] = 0;
      m_mm[i] = 0; m_st[i] = 0; m_halt[i] = 0; m_rdv[i] = 0; m_ovf[i] = 0;
    end else begin
      samp = e && !m_halt[i];
      pop  = r && (exp_q[i].size() > 0);
      m_rdv[i] = pop;
      if (pop) m_rdd[i] = int'(exp_q[i].pop_front());
      if (samp) begin
        if (exp_q[i].size() < DEPTH) exp_q[i].push_back(a);
        else m_ovf[i] = 1;
        dis = (a != b) || (b != g) || (a != g);
        m_mm[i] = dis;
        if (dis) begin
          if (m_err[i] < mx) m_err[i] = m_err[i] + 1;
          if (!m_st[i]) begin
            m_st[i] = 1; m_fec[i] = m_cyc[i]; m_fev[i] = int'({a, b, g});
          end
        end
        m_cyc[i] = m_cyc[i] + 1;
        if (m_cyc[i] == mx) m_halt[i] = 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic mm, input logic es, input logic h,
                          input logic [7:0] cc, input logic [7:0] ec, input logic [7:0] fc,
                          input logic [8:0] fv, input logic rv, input logic [2:0] rd,
                          input logic te, input logic tf, input logic tov);
    chk($sformatf("mismatch%0d", i),   32'(mm),  32'(m_mm[i]));
    chk($sformatf("err_sticky%0d", i), 32'(es),  32'(m_st[i]));
    chk($sformatf("halted%0d", i),     32'(h),   32'(m_halt[i]));
    chk($sformatf("cyc_count%0d", i),  32'(cc),  m_cyc[i]);
    chk($sformatf("err_count%0d", i),  32'(ec),  m_err[i]);
    chk($sformatf("first_cyc%0d", i),  32'(fc),  m_fec[i]);
    chk($sformatf("first_vals%0d", i), 32'(fv),  m_fev[i]);
    chk($sformatf("rd_valid%0d", i),   32'(rv),  32'(m_rdv[i]));
    chk($sformatf("rd_data%0d", i),    32'(rd),  m_rdd[i]);
    chk($sformatf("empty%0d", i),      32'(te),  32'(exp_q[i].size() == 0));
    chk($sformatf("full%0d", i),       32'(tf),  32'(exp_q[i].size() == DEPTH));
    chk($sformatf("ovf%0d", i),        32'(tov), 32'(m_ovf[i]));
  endtask

  task automatic check_all();
    chk_inst(0, mm0, es0, h0, cc0, ec0, fc0, fv0, rv0, rd0, te0, tf0, to0);
    chk_inst(1, mm1, es1, h1, 8'(cc1), 8'(ec1), 8'(fc1), fv1, rv1, rd1, te1, tf1, to1);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit e, input bit c, input bit r,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] g);
    en = e; clr = c; rd_en = r; s_ref = a; s_mem = b; s_gate = g;
    for (int i = 0; i < 2; i++) model_step(i, e, c, r, a, b, g);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic clr_step();
    step(0, 1, 0, 3'd0, 3'd0, 3'd0);
  endtask

  logic [2:0] seq1 [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
  logic [2:0] seq2 [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd1, 3'd2};

  initial begin
    logic [2:0] a, b, g;
    model_reset();
    #12;
    check_all();
    chk("reset_empty", 32'(te0), 32'd1);
    reset = 1'b1;

    // Ten agreeing samples overflow the 8-deep trace.
    for (int k = 0; k < 10; k++) step(1, 0, 0, seq1[k], seq1[k], seq1[k]);
    chk("t1_cyc", 32'(cc0), 32'd10);
    chk("t1_ovf", 32'(to0), 32'd1);

    // Two injected divergences; only the first is latched.
    clr_step();
    for (int k = 0; k < 10; k++) begin
      a = seq2[k]; b = seq2[k]; g = seq2[k];
      if (k == 3) g = 3'd5;
      if (k == 6) b = 3'd4;
      step(1, 0, 0, a, b, g);
      chk("t2_mm", 32'(mm0), 32'((k == 3) || (k == 6)));
    end
    idle_step();
    chk("t2_first_vals", 32'(fv0), 32'o335);
    chk("t2_first_cyc", 32'(fc0), 32'd3);
    chk("t2_err_count", 32'(ec0), 32'd2);

    // Three pushes then four reads; the last read finds the FIFO empty.
    clr_step();
    for (int k = 1; k <= 3; k++) step(1, 0, 0, 3'(k), 3'(k), 3'(k));
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 3'd0, 3'd0, 3'd0);
      if (k <= 3) chk("t3_rd_data", 32'(rd0), 32'(k));
    end
    chk("t3_empty", 32'(te0), 32'd1);

    // Full FIFO with simultaneous push and pop.
    clr_step();
    for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 3'(k), 3'(k), 3'(k));
    step(1, 0, 1, 3'd6, 3'd6, 3'd6);
    chk("t4_oldest", 32'(rd0), 32'd0);
    chk("t4_full", 32'(tf0), 32'd1);
    chk("t4_no_ovf", 32'(to0), 32'd0);

    // Empty FIFO with simultaneous push and pop.
    clr_step();
    step(1, 0, 1, 3'd5, 3'd5, 3'd5);
    chk("t4_empty_pop", 32'(rv0), 32'd0);

    // Randomised traffic with occasional clr.
    clr_step();
    for (int k = 0; k < 300; k++) begin
      a = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : a;
      g = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : a;
      step(bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 60) == 0),
           bit'($urandom_range(0, 1)), a, b, g);
    end

    // Saturation of the 4-bit cycle counter, then recovery by clr.
    clr_step();
    for (int k = 0; k < 20; k++) step(1, 0, bit'(k[0]), 3'(k), 3'(k), 3'(k));
    chk("t5_halted", 32'(h1), 32'd1);
    chk("t5_cyc_frozen", 32'(cc1), 32'd15);
    clr_step();
    chk("t5_clr_cyc", 32'(cc1), 32'd0);
    chk("t5_clr_halt", 32'(h1), 32'd0);

    // Asynchronous reset between edges clears outputs at once.
    for (int k = 0; k < 5; k++) step(1, 0, 0, 3'd2, 3'd2, 3'(k));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // clr alongside en drops the sample and the read.
    step(1, 0, 0, 3'd1, 3'd1, 3'd1);
    step(1, 1, 1, 3'd2, 3'd3, 3'd2);
    chk("t6_clr_cyc", 32'(cc0), 32'd0);
    chk("t6_clr_rv", 32'(rv0), 32'd0);
    step(1, 0, 0, 3'd4, 3'd4, 3'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
